// File: rtl/state_msg_scroller_pkg.sv
// Shared monitor-state and display-character codes used by the message scroller
// and the downstream character-to-segment decoders.
package state_msg_scroller_pkg;

    localparam logic [3:0] STATE_NORMAL     = 4'h0;
    localparam logic [3:0] STATE_BORDERLINE = 4'h1;
    localparam logic [3:0] STATE_ATTENTION  = 4'h2;
    localparam logic [3:0] STATE_EMERGENCY  = 4'h3;

    // Codes 0..9 are the decimal digits; letters follow, blank is the all-ones code.
    localparam logic [4:0] BCD_1     = 5'd1;
    localparam logic [4:0] BCD_A     = 5'd10;
    localparam logic [4:0] BCD_B     = 5'd11;
    localparam logic [4:0] BCD_D     = 5'd13;
    localparam logic [4:0] BCD_F     = 5'd15;
    localparam logic [4:0] BCD_G     = 5'd16;
    localparam logic [4:0] BCD_L     = 5'd17;
    localparam logic [4:0] BCD_N     = 5'd18;
    localparam logic [4:0] BCD_O     = 5'd19;
    localparam logic [4:0] BCD_R     = 5'd20;
    localparam logic [4:0] BCD_T     = 5'd21;
    localparam logic [4:0] BCD_DASH  = 5'd22;
    localparam logic [4:0] BCD_BLANK = 5'd31;

    localparam int MSG_LEN_MAX = 16;

    function automatic logic is_legal_state(input logic [3:0] st);
        return (st == STATE_NORMAL) || (st == STATE_BORDERLINE) ||
               (st == STATE_ATTENTION) || (st == STATE_EMERGENCY);
    endfunction

endpackage

// File: rtl/state_msg_scroller_tick_divider.sv
// Free-running modulo-DIV counter that emits a one-cycle tick on wrap; held at
// zero while disabled or cleared.
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr || !en) begin
            cnt_d = {W{1'b0}};
        end else if (cnt_q == W'(DIV - 1)) begin
            cnt_d = {W{1'b0}};
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/state_msg_scroller.sv
// Registered state-to-message display driver: picks a per-state message, shows a
// circular scrolling window of it and blinks the whole display in emergency.
module state_msg_scroller
    import state_msg_scroller_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int MSG_LEN    = 8,
    parameter int CHAR_W     = 5,
    parameter int SCROLL_DIV = 12_500_000,
    parameter int BLINK_DIV  = 6_250_000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [3:0]                   state,
    input  logic                         scroll_en,
    input  logic                         blink_en,
    output logic [NUM_DIGITS*CHAR_W-1:0] chars,
    output logic [NUM_DIGITS-1:0]        blank,
    output logic                         msg_changed
);

    localparam int   OFF_W     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic SCROLL_OK = (MSG_LEN > NUM_DIGITS) ? 1'b1 : 1'b0;
    localparam logic [CHAR_W-1:0] C_BLANK = CHAR_W'(BCD_BLANK);
    localparam logic [CHAR_W-1:0] C_DASH  = CHAR_W'(BCD_DASH);

    logic [3:0]                   state_q,       state_d;
    logic [OFF_W-1:0]             offset_q,      offset_d;
    logic                         blink_on_q,    blink_on_d;
    logic [NUM_DIGITS*CHAR_W-1:0] chars_q,       chars_d;
    logic [NUM_DIGITS-1:0]        blank_q,       blank_d;
    logic                         msg_changed_q, msg_changed_d;

    logic state_chg_s;
    logic scroll_run_s;
    logic blink_run_s;
    logic scroll_tick_s;
    logic blink_tick_s;

    // Message ROM: four meaningful characters per legal state, blank padding after.
    function automatic logic [CHAR_W-1:0] msg_char(input logic [3:0] st, input int idx);
        logic [4*CHAR_W-1:0] word;
        logic                legal;
        word  = {4{C_DASH}};
        legal = 1'b1;
        case (st)
            STATE_NORMAL:     word = {CHAR_W'(BCD_G), CHAR_W'(BCD_O), CHAR_W'(BCD_O), CHAR_W'(BCD_D)};
            STATE_BORDERLINE: word = {CHAR_W'(BCD_B), CHAR_W'(BCD_O), CHAR_W'(BCD_R), CHAR_W'(BCD_D)};
            STATE_ATTENTION:  word = {CHAR_W'(BCD_A), CHAR_W'(BCD_T), CHAR_W'(BCD_T), CHAR_W'(BCD_N)};
            STATE_EMERGENCY:  word = {CHAR_W'(BCD_F), CHAR_W'(BCD_A), CHAR_W'(BCD_1), CHAR_W'(BCD_L)};
            default:          legal = 1'b0;
        endcase
        if (!legal) begin
            return C_DASH;
        end else if (idx < 4) begin
            return word[(3 - idx)*CHAR_W +: CHAR_W];
        end else begin
            return C_BLANK;
        end
    endfunction

    assign state_chg_s  = (state != state_q);
    assign scroll_run_s = scroll_en & SCROLL_OK;
    assign blink_run_s  = (state_q == STATE_EMERGENCY) & blink_en;

    tick_divider #(.DIV(SCROLL_DIV)) u_scroll_div (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (scroll_run_s),
        .clr  (state_chg_s),
        .tick (scroll_tick_s)
    );

    tick_divider #(.DIV(BLINK_DIV)) u_blink_div (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (blink_run_s),
        .clr  (state_chg_s),
        .tick (blink_tick_s)
    );

    // A state change restarts the message and wins over any tick in the same cycle.
    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        blink_on_d = blink_on_q;
        if (state_chg_s) begin
            state_d    = state;
            offset_d   = {OFF_W{1'b0}};
            blink_on_d = 1'b1;
        end else begin
            if (!scroll_run_s) begin
                offset_d = {OFF_W{1'b0}};
            end else if (scroll_tick_s) begin
                offset_d = (offset_q == OFF_W'(MSG_LEN - 1)) ? {OFF_W{1'b0}} : offset_q + OFF_W'(1);
            end else begin
                offset_d = offset_q;
            end
            if (!blink_run_s) begin
                blink_on_d = 1'b1;
            end else if (blink_tick_s) begin
                blink_on_d = ~blink_on_q;
            end else begin
                blink_on_d = blink_on_q;
            end
        end
    end

    // Window extraction from the latched state; digit NUM_DIGITS-1 is the leftmost.
    always_comb begin
        chars_d       = {NUM_DIGITS{C_BLANK}};
        blank_d       = {NUM_DIGITS{1'b1}};
        msg_changed_d = state_chg_s;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            chars_d[k*CHAR_W +: CHAR_W] =
                msg_char(state_q, (int'(offset_q) + NUM_DIGITS - 1 - k) % MSG_LEN);
            blank_d[k] = ~blink_on_q | (chars_d[k*CHAR_W +: CHAR_W] == C_BLANK);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= STATE_NORMAL;
            offset_q      <= {OFF_W{1'b0}};
            blink_on_q    <= 1'b1;
            chars_q       <= {NUM_DIGITS{C_BLANK}};
            blank_q       <= {NUM_DIGITS{1'b1}};
            msg_changed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            offset_q      <= offset_d;
            blink_on_q    <= blink_on_d;
            chars_q       <= chars_d;
            blank_q       <= blank_d;
            msg_changed_q <= msg_changed_d;
        end
    end

    assign chars       = chars_q;
    assign blank       = blank_q;
    assign msg_changed = msg_changed_q;

endmodule

// File: tb/tb_state_msg_scroller.sv
// Randomized scoreboard bench for state_msg_scroller against a cycle-count based
// reference model of the message window, scrolling and blinking rules.
module tb_state_msg_scroller;
    import state_msg_scroller_pkg::*;

    localparam int ND = 4;
    localparam int ML = 8;
    localparam int CW = 5;
    localparam int SD = 4;
    localparam int BD = 3;

    typedef struct packed {
        logic [ND*CW-1:0] chars;
        logic [ND-1:0]    blank;
        logic             mc;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [3:0]       state;
    logic             scroll_en;
    logic             blink_en;
    logic [ND*CW-1:0] chars;
    logic [ND-1:0]    blank;
    logic             msg_changed;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [3:0] m_state;
    int         m_run;
    int         m_blk;

    state_msg_scroller #(
        .NUM_DIGITS(ND), .MSG_LEN(ML), .CHAR_W(CW), .SCROLL_DIV(SD), .BLINK_DIV(BD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .state(state), .scroll_en(scroll_en),
        .blink_en(blink_en), .chars(chars), .blank(blank), .msg_changed(msg_changed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [4:0] ref_char(input logic [3:0] st, input int idx);
        logic [4:0] txt[4];
        txt = '{BCD_DASH, BCD_DASH, BCD_DASH, BCD_DASH};
        case (st)
            STATE_NORMAL:     txt = '{BCD_G, BCD_O, BCD_O, BCD_D};
            STATE_BORDERLINE: txt = '{BCD_B, BCD_O, BCD_R, BCD_D};
            STATE_ATTENTION:  txt = '{BCD_A, BCD_T, BCD_T, BCD_N};
            STATE_EMERGENCY:  txt = '{BCD_F, BCD_A, BCD_1, BCD_L};
            default:          return BCD_DASH;
        endcase
        if (idx < 4) return txt[idx];
        return BCD_BLANK;
    endfunction

    function automatic int model_offset();
        return (m_run / SD) % ML;
    endfunction

    // Model: offset = running scroll cycles / SD, blink phase = running blink cycles / BD.
    initial begin
        exp_t e;
        logic bon;
        int   off;
        logic [4:0] c;
        m_state = STATE_NORMAL;
        m_run   = 0;
        m_blk   = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                e.chars = {ND{BCD_BLANK}};
                e.blank = {ND{1'b1}};
                e.mc    = 1'b0;
                m_state = STATE_NORMAL;
                m_run   = 0;
                m_blk   = 0;
            end else begin
                bon = ((m_blk / BD) % 2) == 0;
                off = model_offset();
                for (int k = 0; k < ND; k++) begin
                    c = ref_char(m_state, (off + ND - 1 - k) % ML);
                    e.chars[k*CW +: CW] = c;
                    e.blank[k] = !bon || (c == BCD_BLANK);
                end
                e.mc = (state != m_state);
                if (state != m_state) begin
                    m_state = state;
                    m_run   = 0;
                    m_blk   = 0;
                end else begin
                    m_run = (scroll_en && (ML > ND)) ? m_run + 1 : 0;
                    m_blk = (m_state == STATE_EMERGENCY && blink_en) ? m_blk + 1 : 0;
                end
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: one registered output set per cycle, checked away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (chars !== e.chars) begin
                    n_fail++;
                    $display("FAIL chars @%0t: got %h expected %h", $time, chars, e.chars);
                end
                n_cmp++;
                if (blank !== e.blank) begin
                    n_fail++;
                    $display("FAIL blank @%0t: got %b expected %b", $time, blank, e.blank);
                end
                n_cmp++;
                if (msg_changed !== e.mc) begin
                    n_fail++;
                    $display("FAIL msg_changed @%0t: got %b expected %b", $time, msg_changed, e.mc);
                end
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit found;
        int r;
        rst_n     = 1'b0;
        state     = STATE_NORMAL;
        scroll_en = 1'b0;
        blink_en  = 1'b0;
        run(3);
        rst_n = 1'b1;
        run(4);

        // Full marquee lap and wrap back to the start.
        scroll_en = 1'b1;
        run(40);

        // State change mid-scroll at offset 5.
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (model_offset() == 5) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL reach_offset5: got no offset 5 expected offset 5 within 80 cycles");
        end
        state = STATE_BORDERLINE;
        run(10);

        // Emergency blinking, then blink disabled and re-enabled.
        state     = STATE_EMERGENCY;
        scroll_en = 1'b0;
        blink_en  = 1'b1;
        run(20);
        blink_en = 1'b0;
        run(5);
        blink_en = 1'b1;
        run(8);

        // Illegal state code.
        state = 4'hF;
        run(6);

        // Reset while the display is blanked by blinking.
        state = STATE_EMERGENCY;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (m_state == STATE_EMERGENCY && ((m_blk / BD) % 2) == 1) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL reach_blink_off: got blink on expected blink off within 40 cycles");
        end
        @(negedge clk);
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        state = STATE_NORMAL;
        run(5);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            r = $urandom_range(0, 99);
            rst_n = (r == 99) ? 1'b0 : 1'b1;
            if (r < 6) begin
                state = 4'($urandom_range(0, 15));
            end else if (r < 10) begin
                state = 4'($urandom_range(0, 3));
            end else if (r < 13) begin
                state = STATE_EMERGENCY;
            end else if (r < 17) begin
                scroll_en = ~scroll_en;
            end else if (r < 21) begin
                blink_en = ~blink_en;
            end
        end
        rst_n = 1'b1;
        run(3);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
